// File: rtl/traffic_density_detector.sv
// Vehicle-loop conditioning (synchronizer + debouncer), windowed vehicle counting
// and a two-threshold hysteresis FSM that drives the heavy/light traffic flag.
module traffic_density_detector #(
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int WINDOW_CYCLES   = 60,
    parameter int HIGH_THRESH     = 5,
    parameter int LOW_THRESH      = 3,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             veh_sensor,
    output logic             traffic,
    output logic [CNT_W-1:0] veh_count,
    output logic             window_done
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMR_W = $clog2(WINDOW_CYCLES);

    localparam logic [DB_W-1:0]  DB_TOP   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {
        LIGHT = 1'b0,
        HEAVY = 1'b1
    } density_e;

    logic             syncMeta_q;
    logic             syncOut_q;
    logic             db_q, db_d;
    logic [DB_W-1:0]  dbCnt_q, dbCnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] vehCount_q, vehCount_d;
    logic             done_q, done_d;
    density_e         state_q, state_d;

    logic             vehEvent;
    logic             windowEnd;
    logic [CNT_W-1:0] accSum;

    always_ff @(posedge clk) begin
        if (rst) begin
            syncMeta_q <= 1'b0;
            syncOut_q  <= 1'b0;
            db_q       <= 1'b0;
            dbCnt_q    <= '0;
            timer_q    <= '0;
            acc_q      <= '0;
            vehCount_q <= '0;
            done_q     <= 1'b0;
            state_q    <= LIGHT;
        end else begin
            syncMeta_q <= veh_sensor;
            syncOut_q  <= syncMeta_q;
            db_q       <= db_d;
            dbCnt_q    <= dbCnt_d;
            timer_q    <= timer_d;
            acc_q      <= acc_d;
            vehCount_q <= vehCount_d;
            done_q     <= done_d;
            state_q    <= state_d;
        end
    end

    // The debounced level flips on the cycle the disagreement run reaches its limit;
    // a rising flip is the vehicle event, counted on that same edge.
    always_comb begin
        db_d     = db_q;
        dbCnt_d  = '0;
        vehEvent = 1'b0;
        if (syncOut_q != db_q) begin
            if (dbCnt_q == DB_TOP) begin
                db_d     = syncOut_q;
                vehEvent = syncOut_q;
            end else begin
                dbCnt_d = dbCnt_q + 1'b1;
            end
        end
    end

    assign windowEnd = en && (timer_q == TMR_LAST);
    assign accSum    = (vehEvent && en && (acc_q != CNT_MAX)) ? acc_q + 1'b1 : acc_q;

    always_comb begin
        timer_d    = timer_q;
        acc_d      = accSum;
        vehCount_d = vehCount_q;
        done_d     = 1'b0;
        if (windowEnd) begin
            timer_d    = '0;
            acc_d      = '0;
            vehCount_d = accSum;
            done_d     = 1'b1;
        end else if (en) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Density only re-evaluates at a window close, using the count just latched.
    always_comb begin
        state_d = state_q;
        if (windowEnd) begin
            case (state_q)
                LIGHT:   if (int'(accSum) >= HIGH_THRESH) state_d = HEAVY;
                HEAVY:   if (int'(accSum) <= LOW_THRESH)  state_d = LIGHT;
                default: state_d = LIGHT;
            endcase
        end
    end

    assign traffic     = (state_q == HEAVY);
    assign veh_count   = vehCount_q;
    assign window_done = done_q;

endmodule

// File: doc/traffic_density_detector.md
# traffic_density_detector

Upstream sensing stage for the traffic-light signal controller. It conditions a raw, asynchronous vehicle-loop sensor, counts vehicles over fixed observation windows, and drives the one-bit `traffic` level that the signal controller uses to choose long (heavy) or short (light) RED/GREEN dwell times. Hysteresis between two thresholds keeps `traffic` from toggling every window when density sits near a single limit.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 2: consecutive stable synchronized samples required before the debounced level changes; must be ≥1.
- `WINDOW_CYCLES`, default 60: clock cycles per observation window; must be ≥2.
- `HIGH_THRESH`, default 5: the detector enters HEAVY when the window count is ≥ this value.
- `LOW_THRESH`, default 3: the detector returns to LIGHT when the window count is ≤ this value; must be < `HIGH_THRESH`.
- `CNT_W`, default 8: width of the vehicle count.

Ports:
- `clk` in, 1: clock, shared with the signal controller.
- `rst` in, 1: reset, synchronous, active-high.
- `en` in, 1: counting enable.
- `veh_sensor` in, 1: raw loop-detector level, asynchronous, high while a vehicle is present.
- `traffic` out, 1: registered density flag. 1 = HEAVY. Feeds the signal controller.
- `veh_count` out, CNT_W: vehicle count of the most recently closed window.
- `window_done` out, 1: one-cycle pulse, high in the cycle after a window closes.

## Operation

- **Synchronizer:** a two-flop chain on `veh_sensor` produces `s2`.
- **Debouncer:**
  - A counter increments each cycle while `s2` differs from the debounced level `db`.
  - It clears in any cycle where `s2` equals `db`.
  - When the counter reaches `DEBOUNCE_CYCLES`, `db` takes the value of `s2` and the counter clears.
- **Vehicle event:** one event per 0→1 transition of `db`. Falling transitions are not counted.
- **Window timer:**
  - Counts 0..WINDOW_CYCLES-1 and advances only while `en`=1.
  - The terminal cycle is the one where timer = WINDOW_CYCLES-1 and `en`=1.
  - On the terminal edge the timer wraps to 0.
- **Accumulator:**
  - Adds 1 per vehicle event while `en`=1, saturating at 2^CNT_W−1.
  - Events with `en`=0 are discarded.
  - Debouncing continues while `en`=0.
- **Window close (terminal edge):**
  - `veh_count` ← accumulator, including any event in the terminal cycle, saturated.
  - The accumulator clears to 0.
  - `window_done` ← 1 for exactly one cycle.
  - The density FSM evaluates the closed count.
- **Density FSM:**
  - States are LIGHT (`traffic`=0) and HEAVY (`traffic`=1).
  - LIGHT→HEAVY when the closed count ≥ `HIGH_THRESH`.
  - HEAVY→LIGHT when the closed count ≤ `LOW_THRESH`.
  - Otherwise the state holds.
  - The state changes only on a window close.
- **Reset values:** `traffic`=0, `veh_count`=0, `window_done`=0, state LIGHT, timer 0, accumulator 0, sync flops 0, `db`=0, debounce counter 0.

## Timing

- **Raw input to vehicle event:** a clean raw rise sampled at edge k gives `s2`=1 after edge k+1, and `db` rises at edge k+1+DEBOUNCE_CYCLES. The vehicle event is counted on that same edge.
- **Minimum countable pulse:** DEBOUNCE_CYCLES high followed by DEBOUNCE_CYCLES low, in synchronized samples.
- **Glitch rejection:** a pulse shorter than DEBOUNCE_CYCLES samples never changes `db`.
- **First window:** closes WINDOW_CYCLES enabled cycles after `rst` deasserts. `veh_count`, `traffic` and `window_done` all update on that edge.
- **Stale outputs:** `traffic` and `veh_count` hold their values between window closes. The signal controller only ever sees window-aligned changes.
- **Event on the terminal cycle:** the event belongs to the closing window, and the new window starts at 0.
- **`en` deasserted on the terminal cycle:** no close occurs, and the timer holds at WINDOW_CYCLES-1.
- **`rst` mid-window:** the partial count is discarded, all state returns to reset values on the next edge, and a rise in progress must re-debounce from scratch.
- **`rst` and terminal cycle together:** `rst` wins. No `window_done` pulse is produced and `veh_count` becomes 0.

## Test plan

Use DEBOUNCE_CYCLES=2, WINDOW_CYCLES=64, HIGH_THRESH=5, LOW_THRESH=3, CNT_W=8 unless a scenario states otherwise.

1. **Reset:** hold `rst` 3 cycles with `veh_sensor`=1 → `traffic`=0, `veh_count`=0, `window_done`=0 throughout, and no event is counted during reset.
2. **Glitch rejection:** 1-cycle high pulses every 4 cycles for a full window → at edge 64 `veh_count`=0, `window_done` pulses once, `traffic`=0.
3. **Heavy entry:** five 4-high/4-low vehicles in window 1 → at edge 64 `veh_count`=5, `traffic`=1, and `window_done` is high for exactly one cycle.
4. **Hysteresis:**
   - Window 2 with 4 vehicles → `veh_count`=4, `traffic` stays 1.
   - Window 3 with 3 vehicles → `traffic`=0.
   - Window 4 with 4 vehicles → `traffic` stays 0.
5. **Saturation and terminal-cycle event:** with CNT_W=3, nine 2-high/2-low vehicles → `veh_count`=7. Then time a `db` rise on timer=63 → it counts in the closing window and the next window starts at 0.
6. **Mid-window reset and enable:**
   - 4 vehicles, then `rst` at timer=40 → the following window reports only post-reset vehicles.
   - `en`=0 for 10 cycles → window close is delayed by 10 cycles, and vehicles arriving during that time are not counted.
